// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
//   Shared constants for the mux scan sequencer: FSM state codes, the number
//   of mux channels and the select width.
//   No ports (package).
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  // FSM state codes, binary encoded
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Mux geometry
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] chan_t;

  // Last channel of a sweep; reaching it ends the scan, so sel never wraps
  localparam chan_t LAST_CH = chan_t'(N_CH - 1);

endpackage

// File: rtl/mux_scan_sequencer_dwell.sv
// ---------------------------------------------------------------------------
// dwell_counter
//   Counts the settle time spent on one mux channel. The terminal count flag
//   tc is high while the count equals DWELL_CYCLES-1; on an enabled edge with
//   tc high the counter returns to zero so the next channel starts fresh.
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset
//   clr    in  1  synchronous clear (held while not scanning)
//   en     in  1  count enable
//   tc     out 1  count == DWELL_CYCLES-1
// ---------------------------------------------------------------------------
module dwell_counter #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // Comparison value sized to the counter so the compare is CNT_W bits wide
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_LAST);

  // Free-running dwell count while enabled; wraps to zero at the terminal
  // count so DWELL_CYCLES=1 yields tc on every enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//   Select driver and sampler for an eight-to-one mux. In IDLE the manual
//   select is passed (registered) to the mux. A start request sweeps all
//   eight channels, holding each for DWELL_CYCLES cycles, sampling the mux
//   output at the end of each dwell, then publishes the eight samples as one
//   word together with a single-cycle done pulse.
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  synchronous active-high reset
//   start    in  1  scan request, honoured only in IDLE
//   man_sel  in  3  manual channel select used in IDLE
//   mux_c    in  1  mux output (combinational from sel)
//   sel      out 3  registered channel select (sel[2]=s0, sel[1]=s1, sel[0]=s2)
//   busy     out 1  high while scanning
//   done     out 1  one-cycle pulse when word is updated
//   word     out 8  snapshot; word[k] = mux_c sampled while sel==k
// ---------------------------------------------------------------------------
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] man_sel,
  input  logic             mux_c,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  word
);

  logic [1:0]      state;
  logic [N_CH-1:0] stage;
  logic            in_scan;
  logic            dwell_tc;

  assign in_scan = (state == ST_SCAN);

  // The dwell counter is held at zero outside SCAN, which also gives the
  // cnt<=0 behaviour on the start-accept edge.
  dwell_counter #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_scan),
    .en    (in_scan),
    .tc    (dwell_tc)
  );

  // Scan FSM with the select counter, staging register and published word.
  // Samples collect in stage while scanning; word is loaded in one shot on
  // the SCAN->DONE edge (channel 7 goes straight from mux_c) so it is never
  // observed partially updated.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sel   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      word  <= '0;
      stage <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_SCAN;
            sel   <= '0;
            busy  <= 1'b1;
          end else begin
            sel <= man_sel;
          end
        end

        ST_SCAN: begin
          if (dwell_tc) begin
            stage[sel] <= mux_c;
            if (sel != LAST_CH) begin
              sel <= sel + chan_t'(1);
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              word  <= {mux_c, stage[N_CH-2:0]};
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
          sel   <= man_sel;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          sel   <= man_sel;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
//   Self-checking bench for mux_scan_sequencer. Two instances share clock and
//   reset: dut (DWELL_CYCLES=4) and dut1 (DWELL_CYCLES=1). The eight-to-one
//   mux is modelled as pattern[sel]. Expected snapshot words are pushed to a
//   queue when a scan is launched and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;

  logic       start;
  logic [2:0] man_sel;
  logic [7:0] pattern;
  logic       mux_c;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] word;

  logic       start1;
  logic [2:0] man_sel1;
  logic [7:0] pattern1;
  logic       mux_c1;
  logic [2:0] sel1;
  logic       busy1;
  logic       done1;
  logic [7:0] word1;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expq  [$];
  logic [7:0] expq1 [$];

  // Clock generation
  always #5 clk = ~clk;

  // Behavioural eight-to-one mux models
  assign mux_c  = pattern[sel];
  assign mux_c1 = pattern1[sel1];

  mux_scan_sequencer #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .man_sel (man_sel),
    .mux_c   (mux_c),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .word    (word)
  );

  mux_scan_sequencer #(.DWELL_CYCLES(1), .CNT_W(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start1),
    .man_sel (man_sel1),
    .mux_c   (mux_c1),
    .sel     (sel1),
    .busy    (busy1),
    .done    (done1),
    .word    (word1)
  );

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for done on dut; reports how many edges elapsed
  task automatic wait_done(input int limit, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      tick();
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  // Reset behaviour, reset beating start, then manual select pass-through
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start1 = 1'b1;
    man_sel = 3'd6; man_sel1 = 3'd2;
    pattern = 8'h00; pattern1 = 8'h00;
    tick(); tick();
    compared++;
    if (sel !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || word !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_state: sel=%0d busy=%b done=%b word=%h, required 0/0/0/00",
               sel, busy, done, word);
    end
    compared++;
    if (sel1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || word1 !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_state_d1: sel=%0d busy=%b done=%b word=%h, required 0/0/0/00",
               sel1, busy1, done1, word1);
    end
    start = 1'b0; start1 = 1'b0;
    reset = 1'b0;
    man_sel = 3'd5;
    tick();
    compared++;
    if (sel !== 3'd5) begin
      mismatched++;
      $display("[TB] FAIL manual_sel: sel=%0d, required 5", sel);
    end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || word !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL idle_outputs: busy=%b done=%b word=%h, required 0/0/00", busy, done, word);
    end
  endtask

  // Full sweep with cycle-exact select stepping and done timing
  task automatic test_scan();
    logic [7:0] exp;
    pattern = 8'b1010_0110;
    expq.push_back(8'hA6);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 4; d++) begin
        compared++;
        if (sel !== 3'(k)) begin
          mismatched++;
          $display("[TB] FAIL scan_sel ch%0d dwell%0d: sel=%0d, required %0d", k, d, sel, k);
        end
        compared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL scan_status ch%0d dwell%0d: busy=%b done=%b, required 1/0", k, d, busy, done);
        end
        tick();
      end
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || sel !== 3'd7) begin
      mismatched++;
      $display("[TB] FAIL scan_done_timing: done=%b busy=%b sel=%0d, required 1/0/7", done, busy, sel);
    end
    exp = (expq.size() != 0) ? expq.pop_front() : 8'hxx;
    compared++;
    if (word !== exp) begin
      mismatched++;
      $display("[TB] FAIL scan_word: word=%h, required %h", word, exp);
    end
    tick();
    compared++;
    if (done !== 1'b0 || sel !== 3'd5 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL after_done: done=%b sel=%0d busy=%b, required 0/5/0", done, sel, busy);
    end
  endtask

  // A start pulse mid-scan must neither restart nor queue a second scan
  task automatic test_restart_ignored();
    bit         seen;
    int         cyc;
    int         extra_done;
    int         busy_seen;
    logic [7:0] exp;
    pattern = 8'h3C;
    expq.push_back(8'h3C);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, seen, cyc);
    compared++;
    if (!seen || cyc != 26) begin
      mismatched++;
      $display("[TB] FAIL restart_done_timing: seen=%b after %0d cycles, required seen after 26", seen, cyc);
    end
    exp = (expq.size() != 0) ? expq.pop_front() : 8'hxx;
    compared++;
    if (word !== exp) begin
      mismatched++;
      $display("[TB] FAIL restart_word: word=%h, required %h", word, exp);
    end
    extra_done = 0;
    busy_seen  = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) busy_seen++;
    end
    compared++;
    if (extra_done != 0 || busy_seen != 0) begin
      mismatched++;
      $display("[TB] FAIL restart_no_second_scan: done pulses=%0d busy cycles=%0d, required 0/0",
               extra_done, busy_seen);
    end
  endtask

  // Reset during channel 3 aborts the scan and clears the word
  task automatic test_reset_midscan();
    int dones;
    pattern = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    compared++;
    if (sel !== 3'd3 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midscan_position: sel=%0d busy=%b, required 3/1", sel, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (sel !== 3'd0 || busy !== 1'b0 || word !== 8'h00 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midscan_reset: sel=%0d busy=%b word=%h done=%b, required 0/0/00/0",
               sel, busy, word, done);
    end
    dones = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dones++;
    end
    compared++;
    if (dones != 0 || word !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midscan_no_done: done pulses=%0d word=%h, required 0/00", dones, word);
    end
  endtask

  // DWELL_CYCLES=1 with start held: one scan per IDLE visit, period 10
  task automatic test_dwell1_continuous();
    logic [7:0] pats [4];
    logic [7:0] last;
    logic [7:0] exp;
    pats = '{8'h5A, 8'h81, 8'hE7, 8'h24};
    last = 8'h00;
    man_sel1 = 3'd4;
    start1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i % 10 == 1) begin
        pattern1 = pats[i / 10];
        expq1.push_back(pats[i / 10]);
      end
      tick();
      if (i % 10 == 9) begin
        compared++;
        if (done1 !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL d1_done_pulse cycle%0d: done=%b, required 1", i, done1);
        end
        exp = (expq1.size() != 0) ? expq1.pop_front() : 8'hxx;
        compared++;
        if (word1 !== exp) begin
          mismatched++;
          $display("[TB] FAIL d1_word cycle%0d: word=%h, required %h", i, word1, exp);
        end
        last = exp;
      end else begin
        compared++;
        if (done1 !== 1'b0 || word1 !== last) begin
          mismatched++;
          $display("[TB] FAIL d1_between cycle%0d: done=%b word=%h, required 0/%h", i, done1, word1, last);
        end
      end
    end
    start1 = 1'b0;
  endtask

  // Pattern changes after done must not disturb the published word
  task automatic test_pattern_change();
    bit         seen;
    int         cyc;
    logic [7:0] exp;
    pattern = 8'hC3;
    expq.push_back(8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, seen, cyc);
    compared++;
    if (!seen || cyc != 32) begin
      mismatched++;
      $display("[TB] FAIL pc_first_done: seen=%b after %0d cycles, required seen after 32", seen, cyc);
    end
    exp = (expq.size() != 0) ? expq.pop_front() : 8'hxx;
    compared++;
    if (word !== exp) begin
      mismatched++;
      $display("[TB] FAIL pc_first_word: word=%h, required %h", word, exp);
    end
    pattern = 8'h18;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (word !== 8'hC3) begin
        mismatched++;
        $display("[TB] FAIL pc_idle_hold cycle%0d: word=%h, required c3", i, word);
      end
    end
    expq.push_back(8'h18);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (word !== 8'hC3) begin
        mismatched++;
        $display("[TB] FAIL pc_scan_hold cycle%0d: word=%h, required c3", i, word);
      end
    end
    wait_done(40, seen, cyc);
    compared++;
    if (!seen || cyc != 22) begin
      mismatched++;
      $display("[TB] FAIL pc_second_done: seen=%b after %0d cycles, required seen after 22", seen, cyc);
    end
    exp = (expq.size() != 0) ? expq.pop_front() : 8'hxx;
    compared++;
    if (word !== exp) begin
      mismatched++;
      $display("[TB] FAIL pc_second_word: word=%h, required %h", word, exp);
    end
  endtask

  // Top-level sequence of scenarios
  initial begin
    test_reset();
    test_scan();
    test_restart_ignored();
    test_reset_midscan();
    test_dwell1_continuous();
    test_pattern_change();
    compared++;
    if (expq.size() != 0 || expq1.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: left=%0d/%0d, required 0/0", expq.size(), expq1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
